// File: rtl/dcache_line_reader.sv
// Streams one cache line out of the 512x32 data SRAM read port onto a valid/ready
// interface, hiding the 1-cycle SRAM latency and sink backpressure with a 2-entry buffer.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a line completes
// READ  | issuing word reads while the buffer has room
// DRAIN | all words issued; waiting for the last read to land and the last beat to leave
module dcache_line_reader #(
   parameter int ADDR_WIDTH      = 9,
   parameter int DATA_WIDTH      = 32,
   parameter int LINE_WORDS_LOG2 = 3,
   localparam int LINE_IDX_W     = ADDR_WIDTH - LINE_WORDS_LOG2
) (
   input  logic                       rd_clk,
   input  logic                       rd_rst,
   input  logic                       start,
   input  logic [LINE_IDX_W-1:0]      start_line,
   output logic                       busy,
   output logic                       done,
   output logic [ADDR_WIDTH-1:0]      sram_rd_addr,
   input  logic [DATA_WIDTH-1:0]      sram_rd_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [DATA_WIDTH-1:0]      m_data,
   output logic                       m_last,
   output logic [LINE_WORDS_LOG2-1:0] m_word
);

   localparam int CNT_W = LINE_WORDS_LOG2 + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LINE_WORDS_LOG2) - 1);
   localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(1 << LINE_WORDS_LOG2);
   localparam logic [LINE_WORDS_LOG2-1:0] LAST_OFF = '1;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [LINE_IDX_W-1:0]      line_q, line_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       rd_pend_q, rd_pend_d;
   logic [LINE_WORDS_LOG2-1:0] rd_off_q, rd_off_d;
   logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
   logic                       done_q, done_d;

   logic [DATA_WIDTH-1:0]      mem_data_q [2];
   logic [DATA_WIDTH-1:0]      mem_data_d [2];
   logic [LINE_WORDS_LOG2-1:0] mem_word_q [2];
   logic [LINE_WORDS_LOG2-1:0] mem_word_d [2];
   logic                       wr_ptr_q, wr_ptr_d;
   logic                       rd_ptr_q, rd_ptr_d;
   logic [1:0]                 count_q, count_d;

   logic       push, pop, room;
   logic [2:0] occ;

   assign push    = rd_pend_q;
   assign m_valid = (count_q != 2'd0);
   assign pop     = m_valid & m_ready;
   assign m_data  = mem_data_q[rd_ptr_q];
   assign m_word  = mem_word_q[rd_ptr_q];
   assign m_last  = m_valid & (m_word == LAST_OFF);
   assign busy    = (state_q != IDLE);
   assign done    = done_q;

   // Words already buffered plus the one in flight, less the one leaving this cycle.
   assign occ  = {1'b0, count_q} + {2'b00, rd_pend_q} - {2'b00, pop};
   assign room = (occ < 3'd2);

   assign sram_rd_addr = addr_d;

   always_comb begin
      state_d   = state_q;
      line_d    = line_q;
      cnt_d     = cnt_q;
      rd_pend_d = 1'b0;
      rd_off_d  = rd_off_q;
      addr_d    = addr_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               line_d  = start_line;
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            if ((cnt_q < NUM_WORDS) && room) begin
               addr_d    = {line_q, cnt_q[LINE_WORDS_LOG2-1:0]};
               rd_pend_d = 1'b1;
               rd_off_d  = cnt_q[LINE_WORDS_LOG2-1:0];
               cnt_d     = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Finish in the cycle the final beat leaves, so done lands right after it.
            if (!rd_pend_q && (count_q == {1'b0, pop})) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_data_d = mem_data_q;
      mem_word_d = mem_word_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) begin
         mem_data_d[wr_ptr_q] = sram_rd_data;
         mem_word_d[wr_ptr_q] = rd_off_q;
         wr_ptr_d             = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
   end

   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q       <= IDLE;
         line_q        <= '0;
         cnt_q         <= '0;
         rd_pend_q     <= 1'b0;
         rd_off_q      <= '0;
         addr_q        <= '0;
         done_q        <= 1'b0;
         mem_data_q[0] <= '0;
         mem_data_q[1] <= '0;
         mem_word_q[0] <= '0;
         mem_word_q[1] <= '0;
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         count_q       <= '0;
      end else begin
         state_q    <= state_d;
         line_q     <= line_d;
         cnt_q      <= cnt_d;
         rd_pend_q  <= rd_pend_d;
         rd_off_q   <= rd_off_d;
         addr_q     <= addr_d;
         done_q     <= done_d;
         mem_data_q <= mem_data_d;
         mem_word_q <= mem_word_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_dcache_line_reader.sv
// Directed bench for dcache_line_reader: SRAM modelled as data = address, one line per table entry.
module tb_dcache_line_reader;

   logic        rd_clk = 1'b0;
   logic        rd_rst = 1'b1;
   logic        start = 1'b0;
   logic [5:0]  start_line = '0;
   logic        busy, done;
   logic [8:0]  sram_rd_addr;
   logic [31:0] sram_rd_data = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [31:0] m_data;
   logic        m_last;
   logic [2:0]  m_word;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [5:0] line;
      int         mode;     // 0 ready high, 1 stall@beat2 then toggle, 2 toggle, 3 low until cycle 8
      logic [8:0] base;     // hand-computed first word address
      bit         chain;    // extra starts at beat 3 (ignored) and in the done cycle (line 9)
      bit         started;  // start already accepted in the previous done cycle
   } vec_t;

   vec_t vecs [7];

   always #5 rd_clk = ~rd_clk;

   always @(posedge rd_clk) sram_rd_data <= {23'd0, sram_rd_addr};

   dcache_line_reader dut (
      .rd_clk       (rd_clk),
      .rd_rst       (rd_rst),
      .start        (start),
      .start_line   (start_line),
      .busy         (busy),
      .done         (done),
      .sram_rd_addr (sram_rd_addr),
      .sram_rd_data (sram_rd_data),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_word       (m_word)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive inputs 2 time units after the rising edge, leave outputs settled for sampling.
   task automatic step(input logic rst, input logic s, input logic [5:0] l, input logic r);
      @(posedge rd_clk);
      #2;
      rd_rst = rst;
      start = s;
      start_line = l;
      m_ready = r;
      #2;
   endtask

   function automatic logic ready_of(input int mode, input int n);
      case (mode)
         0: return 1'b1;
         1: return (n < 5) ? 1'b1 : (n <= 9) ? 1'b0 : (((n - 10) % 2) == 0);
         2: return (n % 2) == 1;
         3: return n >= 8;
         default: return 1'b1;
      endcase
   endfunction

   task automatic run_line(input vec_t v);
      int          k = 0;
      int          last_beat = -1;
      int          first_beat = -1;
      bit          prev_stall = 0;
      bit          got_done = 0;
      logic [31:0] prev_data = '0;
      logic [2:0]  prev_word = '0;
      logic        s;
      logic [5:0]  l;
      if (!v.started) begin
         step(1'b0, 1'b1, v.line, ready_of(v.mode, 0));
         check("idle_busy", {31'd0, busy}, 32'd0);
      end
      for (int n = 1; n <= 60 && !got_done; n++) begin
         s = 1'b0;
         l = v.line;
         if (v.chain && (n == 6 || n == 11)) begin
            s = 1'b1;
            l = 6'd9;
         end
         step(1'b0, s, l, ready_of(v.mode, n));
         if (prev_stall) begin
            check("hold_valid", {31'd0, m_valid}, 32'd1);
            check("hold_data", m_data, prev_data);
            check("hold_word", {29'd0, m_word}, {29'd0, prev_word});
         end
         if (n == 1) begin
            check("addr_first", {23'd0, sram_rd_addr}, {23'd0, v.base});
            check("busy_on", {31'd0, busy}, 32'd1);
         end
         if (n <= 2) check("valid_early", {31'd0, m_valid}, 32'd0);
         if (n == 3) check("valid_rise", {31'd0, m_valid}, 32'd1);
         if (v.mode == 0 && n <= 8) check("addr_seq", {23'd0, sram_rd_addr}, 32'(v.base) + 32'(n - 1));
         if (v.mode == 3 && n == 5) check("addr_stall", {23'd0, sram_rd_addr}, 32'(v.base) + 32'd1);
         if (busy) check("addr_line", {26'd0, sram_rd_addr[8:3]}, {26'd0, v.base[8:3]});
         if (done) begin
            got_done = 1;
            check("done_after_last", 32'(n), 32'(last_beat + 1));
            check("done_busy", {31'd0, busy}, 32'd0);
            check("beat_count", 32'(k), 32'd8);
         end
         if (m_valid && m_ready) begin
            check("beat_data", m_data, 32'(v.base) + 32'(k));
            check("beat_word", {29'd0, m_word}, 32'(k % 8));
            check("beat_last", {31'd0, m_last}, (k == 7) ? 32'd1 : 32'd0);
            if (k == 0) first_beat = n;
            last_beat = n;
            k++;
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_word  = m_word;
      end
      if (!got_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_timeout: line %0d got %0d beats, no done within 60 cycles", v.line, k);
      end
      if (v.mode == 0 || v.mode == 3) check("burst_len", 32'(last_beat - first_beat), 32'd7);
      if (v.mode == 0) check("first_beat_cycle", 32'(first_beat), 32'd3);
      if (v.mode == 3) check("first_beat_cycle", 32'(first_beat), 32'd8);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{6'd5,  0, 9'h028, 1'b0, 1'b0};
      vecs[1] = '{6'd63, 0, 9'h1F8, 1'b0, 1'b0};
      vecs[2] = '{6'd5,  1, 9'h028, 1'b0, 1'b0};
      vecs[3] = '{6'd42, 2, 9'h150, 1'b0, 1'b0};
      vecs[4] = '{6'd2,  3, 9'h010, 1'b0, 1'b0};
      vecs[5] = '{6'd5,  0, 9'h028, 1'b1, 1'b0};
      vecs[6] = '{6'd9,  0, 9'h048, 1'b0, 1'b1};

      repeat (3) @(posedge rd_clk);
      #2;
      check("rst_busy",   {31'd0, busy},    32'd0);
      check("rst_done",   {31'd0, done},    32'd0);
      check("rst_valid",  {31'd0, m_valid}, 32'd0);
      check("rst_last",   {31'd0, m_last},  32'd0);
      check("rst_data",   m_data,           32'd0);
      check("rst_word",   {29'd0, m_word},  32'd0);
      check("rst_addr",   {23'd0, sram_rd_addr}, 32'd0);

      for (int i = 0; i < 7; i++) run_line(vecs[i]);

      // Reset during beat 4 of line 5, then a clean line 2.
      step(1'b0, 1'b0, 6'd0, 1'b1);
      step(1'b0, 1'b1, 6'd5, 1'b1);
      for (int n = 1; n <= 6; n++) step(1'b0, 1'b0, 6'd5, 1'b1);
      step(1'b1, 1'b0, 6'd5, 1'b1);
      check("mid_rst_beat", m_data, 32'h2C);
      step(1'b0, 1'b0, 6'd5, 1'b1);
      check("mid_rst_busy",  {31'd0, busy},    32'd0);
      check("mid_rst_valid", {31'd0, m_valid}, 32'd0);
      check("mid_rst_done",  {31'd0, done},    32'd0);
      check("mid_rst_addr",  {23'd0, sram_rd_addr}, 32'd0);
      run_line('{6'd2, 0, 9'h010, 1'b0, 1'b0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dcache_line_reader.md
Name: dcache_line_reader

Overview:
- Read-side engine for the 512x32 data-cache SRAM; the write side is the cache fill path.
- Given a line index, reads every word of that line through the SRAM read port (1-cycle latency, no output register).
- Streams the words out on a valid/ready interface with last-beat marking, e.g. toward the write-back/eviction path.
- Absorbs SRAM latency and downstream backpressure with a 2-entry buffer, so a line streams at one word per cycle when the sink never stalls.

Parameters:
- ADDR_WIDTH, 9, SRAM word address width.
- DATA_WIDTH, 32, SRAM word width.
- LINE_WORDS_LOG2, 3, log2 of words per line (default 8 words/line).
- Derived: LINE_IDX_W = ADDR_WIDTH - LINE_WORDS_LOG2 (default 6).

Ports:
- rd_clk  in  1  sole clock; everything is sampled on its rising edge.
- rd_rst  in  1  reset, synchronous, active-high.
- start  in  1  request a line read; accepted only when busy=0.
- start_line  in  LINE_IDX_W  line index, sampled with an accepted start.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse after the last beat handshakes.
- sram_rd_addr  out  ADDR_WIDTH  to the SRAM rd_addr.
- sram_rd_data  in  DATA_WIDTH  from the SRAM rd_data; valid the cycle after the address is presented.
- m_valid  out  1  stream data valid.
- m_ready  in  1  stream sink ready.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks the final word of the line.
- m_word  out  LINE_WORDS_LOG2  word offset of the current m_data within the line.

Behaviour:
- Reset values: busy=0, done=0, m_valid=0, m_last=0, m_data=0, m_word=0, sram_rd_addr=0; FSM=IDLE; buffer empty; issue counter 0; pending-read flag 0.
- The SRAM read clock enable is tied high, so the SRAM reads every cycle. The block tracks validity itself with a registered rd_pend flag. Returned data is pushed into the buffer only when rd_pend=1.
- FSM IDLE:
  - start=1 latches start_line, clears counters, goes to READ.
  - busy=1 from the next cycle.
- FSM READ:
  - A word read is issued in a cycle when issue_cnt < 2^LINE_WORDS_LOG2 and (occupancy + rd_pend - pop) < 2.
  - pop = m_valid & m_ready, evaluated combinationally in the same cycle.
  - Issuing drives sram_rd_addr = {line, issue_cnt}, sets rd_pend for the next cycle, and increments issue_cnt.
  - When not issuing, sram_rd_addr holds its last value.
  - When all words are issued, go to DRAIN.
- FSM DRAIN:
  - Waits until rd_pend=0, the buffer is empty, and the last pop has occurred.
  - Then asserts done for one cycle, drops busy in that same cycle, and returns to IDLE.
  - A new start is accepted in the done cycle.
- Buffer: 2-entry FIFO, with push and pop allowed in the same cycle.
  - m_data, m_word and m_last come from the head entry.
  - m_last=1 only on offset 2^LINE_WORDS_LOG2-1.
  - m_data, m_word and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never deasserts without a handshake.
- Latency:
  - start is sampled at edge E0. Word 0 address is presented in the next cycle and captured at E1. Data is pushed at E2.
  - m_valid is high in the cycle after E2, i.e. 2 cycles after start is sampled.
  - With m_ready held high, all words transfer in consecutive cycles with no bubbles.
- Addressing: there is no wrap across lines. Line index 2^LINE_IDX_W-1 reads the top words of the SRAM, and offsets wrap within the counter only.
- start while busy=1 is ignored, and start_line is not resampled.
- Stalls: m_ready may be low indefinitely; no data is lost or duplicated. The issue rule guarantees the buffer never overflows.
- rd_rst mid-operation takes effect at the next edge: it returns all state to reset values, discards buffered and in-flight words, and does not pulse done.

Test Plan:
- Ready high, start with start_line=5:
  - sram_rd_addr goes 0x028..0x02F on 8 consecutive cycles.
  - With the SRAM modelled as data=addr, m_data=0x28..0x2F on 8 consecutive beats, m_word 0..7, m_last only on 0x2F.
  - done pulses once the cycle after the 8th beat; busy is low in that cycle.
- start_line=63:
  - Addresses 0x1F8..0x1FF, with no access to 0x000.
  - m_last on data 0x1FF.
- Backpressure: m_ready low for 5 cycles starting at beat 2, then toggling 1/0.
  - Beats arrive in exact order 0..7 with no drops or duplicates.
  - m_data is held stable while stalled.
  - No more than 2 words are buffered, and no more than 1 read is outstanding beyond the buffer.
- start pulsed again at beat 3 with start_line=9: ignored, and the stream stays on line 5. A start in the done cycle with line 9 is accepted: the next addresses are 0x048.., and m_valid rises 2 cycles later.
- rd_rst asserted at beat 4 for 1 cycle:
  - Next cycle busy=0, m_valid=0, done=0, sram_rd_addr=0.
  - A following start with line 2 streams 0x10..0x17 cleanly.
- m_ready low from before start:
  - m_valid rises 2 cycles after start and holds word 0.
  - The buffer fills to 2 and issue stalls.
  - On release, 8 beats complete in 8 consecutive cycles.
